// File: rtl/challenge_descrambler.sv
// ---------------------------------------------------------------------------
// challenge_descrambler
//
// Host-side inverse of the PUF challenge scrambler LFSR. A request loads a
// challenge, a step count and a direction; the block then applies one LFSR
// step per clock (inverse or forward) and presents the result with a
// one-cycle done pulse. The result holds until the next accepted request.
//
// Ports:
//   clk        in   1      sole clock, rising edge
//   reset      in   1      asynchronous, active-low reset
//   chall_in   in   WIDTH  challenge to transform, sampled on acceptance
//   steps      in   CNT_W  number of LFSR steps, sampled on acceptance
//   dir        in   1      0 = inverse step, 1 = forward step
//   start      in   1      request, accepted only while idle
//   busy       out  1      high from the cycle after acceptance through done
//   done       out  1      one-cycle pulse, chall_out valid in that cycle
//   chall_out  out  WIDTH  result, held until the next accepted request
// ---------------------------------------------------------------------------
module challenge_descrambler #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
    parameter int               CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] chall_in,
    input  logic [CNT_W-1:0] steps,
    input  logic             dir,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] chall_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] DATA_ZERO = {WIDTH{1'b0}};

    // Even-parity reduction used by both step directions.
    function automatic logic parity(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction

    // One scrambler step: shift left, feed back the tapped parity into bit 0.
    function automatic logic [WIDTH-1:0] lfsr_fwd(input logic [WIDTH-1:0] s);
        return {s[WIDTH-2:0], parity(s & TAPS)};
    endfunction

    // Exact inverse of lfsr_fwd: the old top bit is recovered from the fed-back
    // bit (now bit 0) by removing the contribution of the lower taps.
    function automatic logic [WIDTH-1:0] lfsr_inv(input logic [WIDTH-1:0] n);
        logic [WIDTH-1:0] upper_v;
        logic [WIDTH-1:0] low_taps_v;
        upper_v    = {1'b0, n[WIDTH-1:1]};
        low_taps_v = {1'b0, TAPS[WIDTH-2:0]};
        return {n[0] ^ parity(upper_v & low_taps_v), n[WIDTH-1:1]};
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] data_r;
    logic [WIDTH-1:0] data_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             dir_r;
    logic             dir_nxt_s;
    logic             busy_r;
    logic             busy_nxt_s;
    logic             done_r;
    logic             done_nxt_s;

    // State, datapath and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            data_r  <= DATA_ZERO;
            cnt_r   <= CNT_ZERO;
            dir_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            data_r  <= data_nxt_s;
            cnt_r   <= cnt_nxt_s;
            dir_r   <= dir_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    // Control FSM next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (steps == CNT_ZERO) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // A zero count here can only come from corruption; finishing
                // rather than wrapping keeps the block from running for 2^CNT_W.
                if (cnt_r <= CNT_ONE) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so busy/done come straight off flops.
    always_comb begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
        case (state_nxt_s)
            ST_IDLE: begin
                busy_nxt_s = 1'b0;
                done_nxt_s = 1'b0;
            end
            ST_RUN: begin
                busy_nxt_s = 1'b1;
                done_nxt_s = 1'b0;
            end
            ST_DONE: begin
                busy_nxt_s = 1'b1;
                done_nxt_s = 1'b1;
            end
            default: begin
                busy_nxt_s = 1'b0;
                done_nxt_s = 1'b0;
            end
        endcase
    end

    // Datapath: load on acceptance, step and count down while running.
    always_comb begin
        data_nxt_s = data_r;
        cnt_nxt_s  = cnt_r;
        dir_nxt_s  = dir_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    data_nxt_s = chall_in;
                    cnt_nxt_s  = steps;
                    dir_nxt_s  = dir;
                end else begin
                    data_nxt_s = data_r;
                    cnt_nxt_s  = cnt_r;
                    dir_nxt_s  = dir_r;
                end
            end
            ST_RUN: begin
                if (dir_r) begin
                    data_nxt_s = lfsr_fwd(data_r);
                end else begin
                    data_nxt_s = lfsr_inv(data_r);
                end
                if (cnt_r != CNT_ZERO) begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end else begin
                    cnt_nxt_s = CNT_ZERO;
                end
            end
            ST_DONE: begin
                data_nxt_s = data_r;
                cnt_nxt_s  = cnt_r;
                dir_nxt_s  = dir_r;
            end
            default: begin
                data_nxt_s = data_r;
                cnt_nxt_s  = CNT_ZERO;
                dir_nxt_s  = 1'b0;
            end
        endcase
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign chall_out = data_r;

endmodule

// File: tb/tb_challenge_descrambler.sv
// Scoreboard bench for challenge_descrambler: the driver pushes the expected
// result and the cycle in which done must appear; a monitor pops and compares
// on every done pulse.
module tb_challenge_descrambler;

    logic       clk;
    logic       reset;
    logic [7:0] chall_in;
    logic [7:0] steps;
    logic       dir;
    logic       start;
    logic       busy;
    logic       done;
    logic [7:0] chall_out;

    typedef struct {
        logic [7:0] res;
        int         cyc;
    } exp_t;

    exp_t sb_q[$];
    int   cyc;
    int   n_vec;
    int   n_err;

    challenge_descrambler #(.WIDTH(8), .TAPS(8'hB8), .CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .chall_in  (chall_in),
        .steps     (steps),
        .dir       (dir),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .chall_out (chall_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b1 && done === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL spurious_done: got done=1 expected no pending op (cycle %0d)", cyc);
            end else begin
                e = sb_q.pop_front();
                chk("result", int'(chall_out), int'(e.res));
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end

    // Present one request for a single clock; returns at the negedge after acceptance.
    task automatic issue(input logic [7:0] ci, input logic [7:0] st, input logic d,
                         input logic [7:0] exp_res);
        exp_t e;
        @(negedge clk);
        chall_in = ci;
        steps    = st;
        dir      = d;
        start    = 1'b1;
        e.res    = exp_res;
        e.cyc    = cyc + 1 + int'(st);
        sb_q.push_back(e);
        @(negedge clk);
        start    = 1'b0;
        chall_in = 8'h00;
        steps    = 8'h00;
        dir      = 1'b0;
    endtask

    // Wait (bounded) for all expectations to drain and the block to go idle.
    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while ((sb_q.size() != 0 || busy !== 1'b0) && k < 600) begin
            @(negedge clk);
            #2;
            k++;
        end
        if (k >= 600) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: got %0d pending expected 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    logic [7:0] fwd_tbl [1:8];

    initial begin
        n_vec = 0;
        n_err = 0;
        fwd_tbl[1] = 8'h04; fwd_tbl[2] = 8'h08; fwd_tbl[3] = 8'h11; fwd_tbl[4] = 8'h23;
        fwd_tbl[5] = 8'h47; fwd_tbl[6] = 8'h8E; fwd_tbl[7] = 8'h1C; fwd_tbl[8] = 8'h38;

        reset = 1'b0; start = 1'b0; chall_in = 8'h00; steps = 8'h00; dir = 1'b0;

        // Reset held: outputs idle and zero.
        repeat (3) begin
            @(negedge clk);
            chk("rst_busy", int'(busy), 0);
            chk("rst_done", int'(done), 0);
            chk("rst_out", int'(chall_out), 8'h00);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_out", int'(chall_out), 8'h00);

        // First op: one inverse step from 02.
        issue(8'h02, 8'd1, 1'b0, 8'h01);
        wait_idle("first");

        // Forward sequence 1..8 steps from 02.
        for (int i = 1; i <= 8; i++) begin
            issue(8'h02, 8'(i), 1'b1, fwd_tbl[i]);
            wait_idle("fwd");
        end
        // Result must hold through idle.
        repeat (3) @(negedge clk);
        chk("hold_idle", int'(chall_out), 8'h38);

        // Inverse round-trips.
        issue(8'h38, 8'd8, 1'b0, 8'h02);
        wait_idle("inv8");
        issue(8'hFE, 8'd1, 1'b0, 8'hFF);
        wait_idle("inv1");
        issue(8'h00, 8'd255, 1'b0, 8'h00);
        wait_idle("zero255");

        // Zero steps: done right after acceptance, busy for exactly one cycle.
        issue(8'hA5, 8'd0, 1'b0, 8'hA5);
        chk("zs_busy", int'(busy), 1);
        chk("zs_done", int'(done), 1);
        @(negedge clk);
        chk("zs_busy_drop", int'(busy), 0);
        wait_idle("zero_steps");

        // Start during RUN is ignored.
        issue(8'h38, 8'd8, 1'b0, 8'h02);
        repeat (3) @(negedge clk);
        chall_in = 8'hFF; steps = 8'd1; dir = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("ignored_start");
        repeat (4) @(negedge clk);
        chk("ignored_out", int'(chall_out), 8'h02);

        // start held high: accepted every N+2 cycles.
        @(negedge clk);
        chall_in = 8'h02; steps = 8'd2; dir = 1'b1; start = 1'b1;
        begin
            exp_t e;
            e.res = 8'h08; e.cyc = cyc + 3; sb_q.push_back(e);
            e.res = 8'h08; e.cyc = cyc + 7; sb_q.push_back(e);
        end
        repeat (5) @(negedge clk);
        start = 1'b0;
        wait_idle("b2b");

        // Reset mid-operation clears immediately.
        issue(8'h02, 8'd8, 1'b1, 8'h38);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_out", int'(chall_out), 8'h00);
        sb_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        issue(8'h02, 8'd8, 1'b1, 8'h38);
        wait_idle("after_rst");

        repeat (3) @(negedge clk);
        chk("sb_empty", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
